// File: rtl/return_stack_pkg.sv
// Shared microprocessor constants.
// Holds the default return-address width and return-stack depth. The PC and
// the PC incrementer use the same address width, so all three stay in step.
package return_stack_pkg;

  localparam int addr_width  = 32;
  localparam int stack_depth = 8;

endpackage

// File: rtl/return_stack_mem.sv
// stack_mem: storage array for the return stack.
// A depth x width register array with one synchronous write port and one
// asynchronous read port. The contents are not reset.
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data, combinational from raddr
module stack_mem #(
  parameter int width = 32,
  parameter int depth = 8,
  localparam int aw   = $clog2(depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic [aw-1:0]    raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/return_stack.sv
// return_stack: hardware subroutine return-address stack.
// push writes din on top of the stack (call); pop removes the top (return).
// push and pop together on a non-empty stack replace the top entry in place.
// Requests that would run past either end are dropped and flagged with a
// one-cycle overflow/underflow pulse; the count never wraps.
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset, wins over push/pop
//   push, pop : call / return requests
//   din       : return address to push
//   dout      : current top of stack, 0 when empty (combinational)
//   empty     : no entries
//   full      : depth entries
//   overflow  : registered pulse, a push was rejected
//   underflow : registered pulse, a pop was rejected
module return_stack
  import return_stack_pkg::*;
#(
  parameter int width = addr_width,
  parameter int depth = stack_depth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int cw = $clog2(depth + 1);
  localparam int aw = $clog2(depth);

  logic [cw-1:0]    count;
  logic [cw-1:0]    count_nxt;
  logic [aw-1:0]    top_addr;
  logic [aw-1:0]    waddr;
  logic [width-1:0] rd_data;
  logic             we;
  logic             ovf_nxt;
  logic             unf_nxt;

  assign empty = (count == '0);
  assign full  = (count == cw'(depth));

  // Index of the top entry; only meaningful when not empty.
  assign top_addr = aw'(count - cw'(1));

  always_comb begin
    we        = 1'b0;
    waddr     = count[aw-1:0];
    count_nxt = count;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    if (push && pop && !empty) begin
      // Return-then-call: replace the top, depth unchanged.
      we    = 1'b1;
      waddr = top_addr;
    end else if (push) begin
      // Also covers push+pop on an empty stack, which acts as a plain push.
      if (full) begin
        ovf_nxt = 1'b1;
      end else begin
        we        = 1'b1;
        count_nxt = count + cw'(1);
      end
    end else if (pop) begin
      if (empty) unf_nxt = 1'b1;
      else       count_nxt = count - cw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nxt;
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
    end
  end

  // Write is suppressed during reset so a concurrent push leaves no trace.
  stack_mem #(
    .width (width),
    .depth (depth)
  ) u_mem (
    .clk   (clk),
    .we    (we && rst_n),
    .waddr (waddr),
    .wdata (din),
    .raddr (top_addr),
    .rdata (rd_data)
  );

  assign dout = empty ? '0 : rd_data;

endmodule

// File: tb/tb_return_stack.sv
module tb_return_stack;

  logic        clk;
  logic        rst_n;
  logic        push;
  logic        pop;
  logic [31:0] din;
  logic [31:0] dout;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;

  int n_cmp;
  int n_bad;
  bit checking;

  // Reference model: the stack as a queue, back = top.
  logic [31:0] m_q[$];
  logic        m_ovf;
  logic        m_unf;

  return_stack #(.width(32), .depth(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .din       (din),
    .dout      (dout),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_top();
    if (m_q.size() == 0) return 32'h0;
    return m_q[m_q.size()-1];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic p, input logic po, input logic [31:0] d, input logic rn);
    if (!rn) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
      if (p && po && m_q.size() > 0) m_q[m_q.size()-1] = d;
      else if (p) begin
        if (m_q.size() < 8) m_q.push_back(d);
        else m_ovf = 1'b1;
      end else if (po) begin
        if (m_q.size() > 0) void'(m_q.pop_back());
        else m_unf = 1'b1;
      end
    end
  endtask

  task automatic step(input logic p, input logic po, input logic [31:0] d, input logic rn);
    push  = p;
    pop   = po;
    din   = d;
    rst_n = rn;
    @(posedge clk);
    model_edge(p, po, d, rn);
    #1;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("dout",      dout,              m_top());
      chk("empty",     {31'b0, empty},    {31'b0, m_q.size() == 0});
      chk("full",      {31'b0, full},     {31'b0, m_q.size() == 8});
      chk("overflow",  {31'b0, overflow}, {31'b0, m_ovf});
      chk("underflow", {31'b0, underflow},{31'b0, m_unf});
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    checking = 1'b0;
    push = 1'b0; pop = 1'b0; din = '0; rst_n = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0;

    step(0, 0, 0, 0);
    step(1, 0, 32'hDEAD, 0);
    checking = 1'b1;
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_full",  {31'b0, full},  32'd0);
    chk("rst_dout",  dout,           32'd0);
    chk("rst_ovf",   {31'b0, overflow},  32'd0);
    chk("rst_unf",   {31'b0, underflow}, 32'd0);

    // Push three, pop three.
    step(1, 0, 32'h10, 1);
    step(1, 0, 32'h20, 1);
    step(1, 0, 32'h30, 1);
    chk("lifo_top", dout, 32'h30);
    step(0, 1, 0, 1);
    chk("lifo_pop1", dout, 32'h20);
    step(0, 1, 0, 1);
    chk("lifo_pop2", dout, 32'h10);
    step(0, 1, 0, 1);
    chk("lifo_empty", {31'b0, empty}, 32'd1);
    chk("lifo_dout0", dout, 32'd0);

    // Underflow from empty.
    step(0, 1, 0, 1);
    chk("unf_pulse", {31'b0, underflow}, 32'd1);
    chk("unf_empty", {31'b0, empty}, 32'd1);
    step(0, 0, 0, 1);
    chk("unf_clear", {31'b0, underflow}, 32'd0);
    chk("unf_cnt0",  {31'b0, empty}, 32'd1);

    // Fill, then overflow.
    for (int i = 1; i <= 8; i++) step(1, 0, 32'(i), 1);
    chk("fill_full", {31'b0, full}, 32'd1);
    chk("fill_top",  dout, 32'd8);
    step(1, 0, 32'd9, 1);
    chk("ovf_pulse", {31'b0, overflow}, 32'd1);
    chk("ovf_top",   dout, 32'd8);
    step(0, 0, 0, 1);
    chk("ovf_clear", {31'b0, overflow}, 32'd0);
    // Push+pop on full replaces top, no flags.
    step(1, 1, 32'h77, 1);
    chk("full_repl_top", dout, 32'h77);
    chk("full_repl_ovf", {31'b0, overflow}, 32'd0);
    chk("full_repl_full", {31'b0, full}, 32'd1);

    // Replace top on a one-entry stack.
    step(0, 0, 0, 0);
    step(1, 0, 32'h5, 1);
    step(1, 1, 32'h7, 1);
    chk("repl_top", dout, 32'h7);
    step(0, 1, 0, 1);
    chk("repl_cnt1", {31'b0, empty}, 32'd1);
    // Push+pop on empty acts as a push.
    step(1, 1, 32'h7, 1);
    chk("epp_top", dout, 32'h7);
    chk("epp_unf", {31'b0, underflow}, 32'd0);
    step(0, 1, 0, 1);
    chk("epp_cnt1", {31'b0, empty}, 32'd1);

    // Reset mid-sequence beats a concurrent push.
    step(1, 0, 32'h1, 1);
    step(1, 0, 32'h2, 1);
    step(1, 0, 32'h3, 1);
    step(1, 0, 32'h4, 0);
    chk("mid_rst_empty", {31'b0, empty}, 32'd1);
    chk("mid_rst_dout",  dout, 32'd0);
    step(1, 0, 32'hA, 1);
    chk("post_rst_top", dout, 32'hA);
    step(0, 1, 0, 1);
    chk("post_rst_cnt1", {31'b0, empty}, 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic p, po, rn;
      int mode;
      mode = (i / 300) % 3;
      rn = ($urandom_range(0, 79) != 0);
      if (mode == 0) begin
        p  = ($urandom_range(0, 99) < 70);
        po = ($urandom_range(0, 99) < 25);
      end else if (mode == 1) begin
        p  = ($urandom_range(0, 99) < 25);
        po = ($urandom_range(0, 99) < 70);
      end else begin
        p  = $urandom_range(0, 1) != 0;
        po = $urandom_range(0, 1) != 0;
      end
      step(p, po, $urandom, rn);
    end

    step(0, 0, 0, 1);
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/return_stack.md
RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 SHALL have parameter width, default 32, bit width of each stored return address.
REQ-002 SHALL have parameter depth, default 8, number of entries (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port push  input  1  request to write din onto the top of stack (subroutine call).
REQ-006 SHALL have port pop  input  1  request to remove the top entry (subroutine return).
REQ-007 SHALL have port din  input  width  return address to push (the incremented PC).
REQ-008 SHALL have port dout  output  width  current top-of-stack value.
REQ-009 SHALL have port empty  output  1  high when the entry count is 0.
REQ-010 SHALL have port full  output  1  high when the entry count equals depth.
REQ-011 SHALL have port overflow  output  1  one-cycle pulse: push rejected.
REQ-012 SHALL have port underflow  output  1  one-cycle pulse: pop rejected.

Function
REQ-013 SHALL keep the entry count in a register of $clog2(depth+1) bits, range 0..depth.
REQ-014 SHALL drive dout combinationally from the stored top entry, giving zero-latency read of the top; dout SHALL be 0 when empty.
REQ-015 SHALL, on push alone with not full: write din at index count and increment count; the new value appears on dout the following cycle.
REQ-016 SHALL, on pop alone with not empty: decrement count; the entry below appears on dout the following cycle.
REQ-017 SHALL, on push alone with full: leave storage and count unchanged and assert overflow for exactly the next cycle.
REQ-018 SHALL, on pop alone with empty: leave state unchanged and assert underflow for exactly the next cycle.
REQ-019 SHALL, on push and pop together with not empty (including full): overwrite the top entry with din, count unchanged, no overflow or underflow.
REQ-020 SHALL, on push and pop together with empty: behave as push alone, with no underflow.
REQ-021 SHALL register overflow and underflow, deasserting them one cycle after assertion unless a new rejected request occurs.
REQ-022 SHALL derive empty and full combinationally from the count register.
REQ-023 SHALL never wrap the count; rejected requests are the only boundary response.

Reset
REQ-024 SHALL, when rst_n is low at a rising clk edge, set count to 0, overflow to 0 and underflow to 0, giving empty=1, full=0, dout=0.
REQ-025 SHALL give reset priority over push and pop in the same cycle, including mid-sequence, discarding all stacked entries.
REQ-026 SHALL leave the storage array un-reset; its contents are unobservable while empty.

Structure
REQ-027 SHALL place the default address width (32) and default stack depth (8) as constants in the shared microprocessor package, also used by the PC and incrementer.
REQ-028 SHALL implement storage as one sub-module, stack_mem: depth x width register array, one synchronous write port and one asynchronous read port.
REQ-029 SHALL keep count, flag logic and the push/pop decision in return_stack itself; no explicit FSM beyond the count register.

Verification
REQ-030 SHALL cover reset then push 0x10, 0x20, 0x30 -> dout 0x30, 0x20, 0x10 on three successive pops, then empty=1 and dout=0.
REQ-031 SHALL cover 8 pushes of 1..8 -> full=1, dout=8; a ninth push of 9 -> overflow high one cycle, dout stays 8.
REQ-032 SHALL cover pop from reset state -> underflow high one cycle, empty stays 1, count stays 0.
REQ-033 SHALL cover stack holding 0x5, then push 0x7 with pop in the same cycle -> dout=0x7, count=1; same on an empty stack -> dout=0x7, count=1, underflow=0.
REQ-034 SHALL cover 3 entries pushed, then rst_n low for one cycle concurrently with push -> empty=1, dout=0, and the next push of 0xA gives dout=0xA with count=1.
